// File: rtl/aes_uart_cfg_seq_if.sv
// AXI4-Lite bus bundle between the AES_UART configuration sequencer (master)
// and the AES_UART register block (slave). The data path is always 32 bits wide.
interface aes_uart_cfg_seq_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/aes_uart_cfg_seq.sv
// AXI4-Lite master that writes a 128-bit key and a control word into AES_UART,
// then (with AES_CFG_POLL_EN defined) polls the status register until ready.
module aes_uart_cfg_seq #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] KEY_BASE  = 'h10,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = 'h00,
    parameter logic [31:0]       CTRL_VAL  = 32'h1,
    parameter logic [ADDR_W-1:0] STAT_ADDR = 'h04,
    parameter int unsigned       POLL_MAX  = 16
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Start,
    input  logic [127:0]              Key,
    output logic                      Done,
    output logic                      Err,
    aes_uart_cfg_seq_if.master        m_axi
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WREQ = 3'd1;
    localparam logic [2:0] S_WRSP = 3'd2;
`ifdef AES_CFG_POLL_EN
    localparam logic [2:0] S_RREQ = 3'd3;
    localparam logic [2:0] S_RRSP = 3'd4;
    localparam int unsigned PCW   = $clog2(POLL_MAX + 1);
`endif
    localparam logic [2:0] IDX_CTRL = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [2:0]   idx_q, idx_d;
    logic         aw_done_q, aw_done_d;
    logic         w_done_q, w_done_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
`ifdef AES_CFG_POLL_EN
    logic [PCW-1:0] poll_q, poll_d;
`endif

    logic [31:0]       key_word [4];
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    for (genvar gi = 0; gi < 4; gi++) begin : g_key_word
        assign key_word[gi] = key_q[32*gi +: 32];
    end

    assign wr_addr = (idx_q == IDX_CTRL) ? CTRL_ADDR
                                         : KEY_BASE + ADDR_W'({idx_q[1:0], 2'b00});
    assign wr_data = (idx_q == IDX_CTRL) ? CTRL_VAL : key_word[idx_q[1:0]];

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        idx_d     = idx_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        done_d    = 1'b0;
        err_d     = err_q;
`ifdef AES_CFG_POLL_EN
        poll_d    = poll_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A Start coinciding with the Done pulse is deliberately dropped.
                if (Start && !done_q) begin
                    key_d     = Key;
                    err_d     = 1'b0;
                    idx_d     = 3'd0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
`ifdef AES_CFG_POLL_EN
                    poll_d    = '0;
`endif
                    state_d   = S_WREQ;
                end
            end
            S_WREQ: begin
                if (m_axi.awready) aw_done_d = 1'b1;
                if (m_axi.wready)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WRSP;
                end
            end
            S_WRSP: begin
                if (m_axi.bvalid) begin
                    if (m_axi.bresp != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (idx_q < IDX_CTRL) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_WREQ;
                    end else begin
`ifdef AES_CFG_POLL_EN
                        state_d = S_RREQ;
`else
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end
                end
            end
`ifdef AES_CFG_POLL_EN
            S_RREQ: begin
                if (m_axi.arready) state_d = S_RRSP;
            end
            S_RRSP: begin
                if (m_axi.rvalid) begin
                    if (m_axi.rresp != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (m_axi.rdata[0]) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        poll_d = poll_q + PCW'(1);
                        if (poll_d == PCW'(POLL_MAX)) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_RREQ;
                        end
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            key_q     <= '0;
            idx_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef AES_CFG_POLL_EN
            poll_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            idx_q     <= idx_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef AES_CFG_POLL_EN
            poll_q    <= poll_d;
`endif
        end
    end

    // Bus outputs decode registered state only, so they are stable while valid.
    assign m_axi.awvalid = (state_q == S_WREQ) && !aw_done_q;
    assign m_axi.wvalid  = (state_q == S_WREQ) && !w_done_q;
    assign m_axi.awaddr  = (state_q == S_WREQ) ? wr_addr : '0;
    assign m_axi.wdata   = (state_q == S_WREQ) ? wr_data : '0;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.bready  = (state_q == S_WRSP);

`ifdef AES_CFG_POLL_EN
    assign m_axi.arvalid = (state_q == S_RREQ);
    assign m_axi.araddr  = (state_q == S_RREQ) ? STAT_ADDR : '0;
    assign m_axi.rready  = (state_q == S_RRSP);

    logic unused_cfg;
    assign unused_cfg = ^m_axi.rdata[31:1];
`else
    assign m_axi.arvalid = 1'b0;
    assign m_axi.araddr  = '0;
    assign m_axi.rready  = 1'b0;

    logic unused_cfg;
    assign unused_cfg = ^{m_axi.arready, m_axi.rdata, m_axi.rresp, m_axi.rvalid,
                          STAT_ADDR, POLL_MAX};
`endif

    assign Done = done_q;
    assign Err  = err_q;

endmodule

// File: tb/tb_aes_uart_cfg_seq.sv
// Directed bench for aes_uart_cfg_seq: a behavioural AXI4-Lite slave with
// programmable ready latency, write-error injection and status sequencing.
module tb_aes_uart_cfg_seq;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key   = '0;
    logic         done;
    logic         err;

    aes_uart_cfg_seq_if #(.ADDR_W(32)) bus ();

    aes_uart_cfg_seq dut (
        .Clk   (clk),
        .Rst   (rst),
        .Start (start),
        .Key   (key),
        .Done  (done),
        .Err   (err),
        .m_axi (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slave model (all activity on the falling edge) ----------------
    int n_aw = 0, n_w = 0, n_ar = 0, nb_issued = 0;
    int aw_age = 0, w_age = 0;
    int aw_lat = 0, w_lat = 0, berr_at = -1, rone_at = 0;
    int done_total = 0, stab_bad = 0, strb_bad = 0, rready_seen = 0;
    logic [31:0] aw_log [128];
    logic [31:0] w_log  [128];
    logic aw_hs = 1'b0, w_hs = 1'b0, b_hs = 1'b0, ar_hs = 1'b0, r_hs = 1'b0;
    logic awv_prev = 1'b0, wv_prev = 1'b0;
    logic [31:0] aw_cap = '0, w_cap = '0, aw_prev = '0, w_prev = '0;

    always @(negedge clk) begin
        if (rst) begin
            bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
            bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;    bus.rresp = 2'b00;
            aw_hs = 1'b0; w_hs = 1'b0; b_hs = 1'b0; ar_hs = 1'b0; r_hs = 1'b0;
            aw_age = 0; w_age = 0; awv_prev = 1'b0; wv_prev = 1'b0;
            if (n_aw > n_w) n_w = n_aw; else n_aw = n_w;
            nb_issued = n_aw;
        end else begin
            if (done) done_total++;
            if (bus.rready) rready_seen++;
            // handshakes completed at the rising edge just passed
            if (aw_hs) begin aw_log[n_aw % 128] = aw_cap; n_aw++; end
            if (w_hs)  begin w_log[n_w % 128]   = w_cap;  n_w++;  end
            if (b_hs)  bus.bvalid = 1'b0;
            if (r_hs)  bus.rvalid = 1'b0;
            if (ar_hs) begin
                bus.rvalid = 1'b1;
                bus.rresp  = 2'b00;
                bus.rdata  = (n_ar >= rone_at) ? 32'h8000_0001 : 32'hFFFF_FFFE;
                n_ar++;
            end
            if (!bus.bvalid && n_aw > nb_issued && n_w > nb_issued) begin
                bus.bvalid = 1'b1;
                bus.bresp  = (nb_issued == berr_at) ? 2'b10 : 2'b00;
                nb_issued++;
            end
            // valid held and payload stable until accepted
            if (awv_prev && !aw_hs && (!bus.awvalid || bus.awaddr != aw_prev)) stab_bad++;
            if (wv_prev  && !w_hs  && (!bus.wvalid  || bus.wdata  != w_prev))  stab_bad++;
            if (bus.wvalid && bus.wstrb != 4'hF) strb_bad++;
            awv_prev = bus.awvalid; aw_prev = bus.awaddr;
            wv_prev  = bus.wvalid;  w_prev  = bus.wdata;
            // ready decisions for the current cycle
            bus.awready = bus.awvalid && (aw_age >= aw_lat);
            bus.wready  = bus.wvalid  && (w_age  >= w_lat);
            bus.arready = bus.arvalid;
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid  && bus.wready;
            b_hs  = bus.bvalid  && bus.bready;
            ar_hs = bus.arvalid && bus.arready;
            r_hs  = bus.rvalid  && bus.rready;
            aw_cap = bus.awaddr; w_cap = bus.wdata;
            aw_age = aw_hs ? 0 : (bus.awvalid ? aw_age + 1 : 0);
            w_age  = w_hs  ? 0 : (bus.wvalid  ? w_age  + 1 : 0);
        end
    end

    // Called right after a falling edge; returns cycles from Start sample to Done/Err.
    task automatic run_vec(input logic [127:0] k, output int cyc);
        key   = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_clear_on_start", err, 1'b0);
        cyc = -1;
        for (int kk = 1; kk <= 200; kk++) begin
            if (done || err) begin
                cyc = kk;
                break;
            end
            @(negedge clk);
        end
        if (cyc < 0) begin
            n_checks++; n_errors++;
            $display("FAIL timeout: got no Done/Err, expected one within 200 cycles");
        end
        repeat (6) @(negedge clk);
    endtask

    typedef struct {
        int           aw_lat;
        int           w_lat;
        int           berr;     // write index answered with SLVERR, -1 none
        int           rzeros;   // status reads returning 0 before ready
        logic [127:0] key;
        int           exp_w;
        int           exp_r;
        int           exp_done;
        logic         exp_err;
        int           exp_cyc;
    } vec_t;

    localparam logic [127:0] KEY0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] KEYA = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] KEYB = 128'h11111111_22222222_33333333_44444444;

    vec_t vecs [7];

    initial begin
        int cyc, b_aw, b_w, b_ar, b_done;
        logic [31:0] exp_a, exp_d;
        logic [127:0] kv;

`ifdef AES_CFG_POLL_EN
        vecs[0] = '{0, 0, -1, 0,    KEY0, 5, 1,  1, 1'b0, 13};
        vecs[1] = '{0, 3, -1, 0,    KEYA, 5, 1,  1, 1'b0, 28};
        vecs[2] = '{0, 0,  1, 0,    KEYB, 2, 0,  0, 1'b1, 5};
        vecs[3] = '{0, 0, -1, 3,    KEYA, 5, 4,  1, 1'b0, 19};
        vecs[4] = '{0, 0, -1, 1000, KEYB, 5, 16, 0, 1'b1, 43};
        vecs[5] = '{2, 0,  4, 0,    KEYA, 5, 0,  0, 1'b1, 21};
        vecs[6] = '{0, 0, -1, 0,    KEY0, 5, 1,  1, 1'b0, 13};
`else
        vecs[0] = '{0, 0, -1, 0,    KEY0, 5, 0, 1, 1'b0, 11};
        vecs[1] = '{0, 3, -1, 0,    KEYA, 5, 0, 1, 1'b0, 26};
        vecs[2] = '{0, 0,  1, 0,    KEYB, 2, 0, 0, 1'b1, 5};
        vecs[3] = '{0, 0, -1, 3,    KEYA, 5, 0, 1, 1'b0, 11};
        vecs[4] = '{0, 0, -1, 1000, KEYB, 5, 0, 1, 1'b0, 11};
        vecs[5] = '{2, 0,  4, 0,    KEYA, 5, 0, 0, 1'b1, 21};
        vecs[6] = '{0, 0, -1, 0,    KEY0, 5, 0, 1, 1'b0, 11};
`endif

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready,
               done, err, |bus.awaddr, |bus.wdata, |bus.araddr}, 10'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            aw_lat  = vecs[v].aw_lat;
            w_lat   = vecs[v].w_lat;
            b_aw = n_aw; b_w = n_w; b_ar = n_ar; b_done = done_total;
            berr_at = (vecs[v].berr < 0) ? -1 : b_aw + vecs[v].berr;
            rone_at = b_ar + vecs[v].rzeros;
            run_vec(vecs[v].key, cyc);
            $display("vec %0d: cycles=%0d writes=%0d reads=%0d done=%0d err=%0b",
                     v, cyc, n_aw - b_aw, n_ar - b_ar, done_total - b_done, err);
            check($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cyc);
            check($sformatf("v%0d_aw_count", v), n_aw - b_aw, vecs[v].exp_w);
            check($sformatf("v%0d_w_count", v), n_w - b_w, vecs[v].exp_w);
            check($sformatf("v%0d_ar_count", v), n_ar - b_ar, vecs[v].exp_r);
            check($sformatf("v%0d_done_count", v), done_total - b_done, vecs[v].exp_done);
            check($sformatf("v%0d_err", v), err, vecs[v].exp_err);
            kv = vecs[v].key;
            for (int i = 0; i < vecs[v].exp_w && i < 5; i++) begin
                exp_a = (i < 4) ? 32'h10 + 32'(4 * i) : 32'h0;
                exp_d = (i < 4) ? kv[32*i +: 32] : 32'h1;
                check($sformatf("v%0d_wr%0d_addr_data", v, i),
                      {aw_log[(b_aw + i) % 128], w_log[(b_w + i) % 128]}, {exp_a, exp_d});
            end
        end

        // hand-computed payload of the first vector
        check("key_word0", w_log[0], 32'h03020100);
        check("key_word3", {aw_log[3], w_log[3]}, {32'h1C, 32'h0F0E0D0C});

        // reset while waiting for the first write response, then replay
        aw_lat = 0; w_lat = 0; berr_at = -1; rone_at = n_ar;
        key = KEYB; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("wrsp_bready", bus.bready, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_wrsp_outputs",
              {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready,
               done, err, |bus.awaddr, |bus.wdata, |bus.araddr}, 10'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_rst", {bus.awvalid, bus.wvalid}, 2'b00);
        b_aw = n_aw; b_done = done_total; rone_at = n_ar;
        run_vec(KEYA, cyc);
        $display("replay: cycles=%0d writes=%0d done=%0d", cyc, n_aw - b_aw, done_total - b_done);
`ifdef AES_CFG_POLL_EN
        check("replay_cycles", cyc, 13);
`else
        check("replay_cycles", cyc, 11);
`endif
        check("replay_writes", n_aw - b_aw, 5);
        check("replay_first_write", {aw_log[b_aw % 128], w_log[b_aw % 128]},
              {32'h10, 32'h89ABCDEF});
        check("replay_done", done_total - b_done, 1);

        // Start asserted while Done is high must be ignored
        b_aw = n_aw; b_done = done_total; rone_at = n_ar;
        key = KEY0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = -1;
        for (int kk = 1; kk <= 200; kk++) begin
            if (done) begin cyc = kk; break; end
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        $display("start_on_done: cycles=%0d writes=%0d done=%0d", cyc, n_aw - b_aw, done_total - b_done);
        check("start_on_done_found", cyc > 0, 1'b1);
        check("start_on_done_writes", n_aw - b_aw, 5);
        check("start_on_done_busy", bus.awvalid, 1'b0);
        check("start_on_done_pulses", done_total - b_done, 1);

        check("valid_stability", stab_bad, 0);
        check("wstrb_all_ones", strb_bad, 0);
`ifndef AES_CFG_POLL_EN
        check("rready_tied_low", rready_seen, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
